// File: rtl/cordic_gain_comp.sv
// CORDIC output stage: gain compensation by K, round, optional flip, saturate.
// Two-stage valid/ready pipeline with a global enable and a sticky saturation counter.
module cordic_gain_comp #(
   parameter int          FRAC_BITS = 16,
   parameter logic [31:0] K_CONST   = 32'h0000_9B75
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [31:0] x,
   input  logic signed [31:0] y,
   input  logic        [31:0] z,
   input  logic               in_flip,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [31:0] x_out,
   output logic signed [31:0] y_out,
   output logic        [31:0] z_out,
   output logic               sat_flag,
   output logic        [15:0] sat_count
);

   localparam logic signed [63:0] K_EXT = {32'b0, K_CONST};
   localparam logic signed [63:0] HALF  = 64'sd1 <<< (FRAC_BITS - 1);
   localparam logic signed [63:0] Q_MAX = 64'sd2147483647;
   localparam logic signed [63:0] Q_MIN = -64'sd2147483648;

   logic               en;
   logic               v1;
   logic               v2;
   logic               flip1;
   logic signed [63:0] px;
   logic signed [63:0] py;
   logic        [31:0] z1;
   logic        [32:0] cx;
   logic        [32:0] cy;

   // Whole pipeline advances together: it moves unless the output beat is stuck.
   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign out_valid = v2;

   // Returns {saturated, value}: round half toward +inf, drop fraction, flip, clamp.
   function automatic logic [32:0] compensate(input logic signed [63:0] p, input logic flip);
      logic signed [63:0] q;
      q = (p + HALF) >>> FRAC_BITS;
      if (flip) q = -q;
      if (q > Q_MAX) return {1'b1, 32'h7FFF_FFFF};
      if (q < Q_MIN) return {1'b1, 32'h8000_0000};
      return {1'b0, q[31:0]};
   endfunction

   assign cx = compensate(px, flip1);
   assign cy = compensate(py, flip1);

   // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px    <= '0;
         py    <= '0;
         z1    <= '0;
         flip1 <= 1'b0;
         v1    <= 1'b0;
      end else if (en) begin
         px    <= x * K_EXT;
         py    <= y * K_EXT;
         z1    <= z;
         flip1 <= in_flip;
         v1    <= in_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_out    <= '0;
         y_out    <= '0;
         z_out    <= '0;
         sat_flag <= 1'b0;
         v2       <= 1'b0;
      end else if (en) begin
         x_out    <= cx[31:0];
         y_out    <= cy[31:0];
         z_out    <= z1;
         sat_flag <= cx[32] | cy[32];
         v2       <= v1;
      end
   end

   // Counts on the same edge the saturated beat leaves; sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && sat_flag && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Bench for cordic_gain_comp: two instances (default K and K = 2.0) share stimulus
// and are compared every cycle against an arithmetic reference pipeline.
module tb_cordic_gain_comp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] x;
   logic [31:0] y;
   logic [31:0] z;
   logic        in_flip;
   logic        out_ready;

   logic        ir_a, ov_a, sf_a, ir_b, ov_b, sf_b;
   logic [31:0] xo_a, yo_a, zo_a, xo_b, yo_b, zo_b;
   logic [15:0] sc_a, sc_b;

   always #5 clk = ~clk;

   cordic_gain_comp dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a),
      .x(x), .y(y), .z(z), .in_flip(in_flip),
      .out_valid(ov_a), .out_ready(out_ready),
      .x_out(xo_a), .y_out(yo_a), .z_out(zo_a), .sat_flag(sf_a), .sat_count(sc_a)
   );

   cordic_gain_comp #(.K_CONST(32'h0002_0000)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b),
      .x(x), .y(y), .z(z), .in_flip(in_flip),
      .out_valid(ov_b), .out_ready(out_ready),
      .x_out(xo_b), .y_out(yo_b), .z_out(zo_b), .sat_flag(sf_b), .sat_count(sc_b)
   );

   typedef struct packed {
      logic        v;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic        f;
   } beat_t;

   localparam longint K_A = 64'd39797;   // 0x9B75
   localparam longint K_B = 64'd131072;  // 0x0002_0000

   beat_t       m_s1, m_s2;
   int unsigned cnt_a, cnt_b;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Exact result from real-number rules: floor((a*K)/2^16 + 1/2), negate, clamp.
   function automatic logic [32:0] ref_calc(input logic [31:0] a, input logic fl, input longint k);
      longint n, q;
      n = longint'($signed(a)) * k + 64'sd32768;
      q = (n >= 0) ? n / 64'sd65536 : -((-n + 64'sd65535) / 64'sd65536);
      if (fl) q = -q;
      if (q > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
      if (q < -64'sd2147483648) return {1'b1, 32'h8000_0000};
      return {1'b0, q[31:0]};
   endfunction

   task automatic model_reset();
      m_s1  = '0;
      m_s2  = '0;
      cnt_a = 0;
      cnt_b = 0;
   endtask

   task automatic model_edge(input beat_t nb, input logic ordy);
      logic [32:0] ax, ay, bx, by;
      if (m_s2.v && ordy) begin
         ax = ref_calc(m_s2.x, m_s2.f, K_A);
         ay = ref_calc(m_s2.y, m_s2.f, K_A);
         bx = ref_calc(m_s2.x, m_s2.f, K_B);
         by = ref_calc(m_s2.y, m_s2.f, K_B);
         if ((ax[32] || ay[32]) && cnt_a < 65535) cnt_a++;
         if ((bx[32] || by[32]) && cnt_b < 65535) cnt_b++;
      end
      if (!m_s2.v || ordy) begin
         m_s2 = m_s1;
         m_s1 = nb;
      end
   endtask

   task automatic check_outputs();
      logic [32:0] ax, ay, bx, by;
      check("out_valid_a", ov_a, m_s2.v);
      check("out_valid_b", ov_b, m_s2.v);
      check("sat_count_a", sc_a, cnt_a);
      check("sat_count_b", sc_b, cnt_b);
      if (m_s2.v) begin
         ax = ref_calc(m_s2.x, m_s2.f, K_A);
         ay = ref_calc(m_s2.y, m_s2.f, K_A);
         bx = ref_calc(m_s2.x, m_s2.f, K_B);
         by = ref_calc(m_s2.y, m_s2.f, K_B);
         check("x_out_a", xo_a, ax[31:0]);
         check("y_out_a", yo_a, ay[31:0]);
         check("z_out_a", zo_a, m_s2.z);
         check("sat_flag_a", sf_a, ax[32] | ay[32]);
         check("x_out_b", xo_b, bx[31:0]);
         check("y_out_b", yo_b, by[31:0]);
         check("z_out_b", zo_b, m_s2.z);
         check("sat_flag_b", sf_b, bx[32] | by[32]);
      end
   endtask

   // One clock: drive at negedge, check in_ready, step model at posedge, check at next negedge.
   task automatic cycle(input logic iv, input logic [31:0] xi, input logic [31:0] yi,
                        input logic [31:0] zi, input logic fl, input logic ordy,
                        output logic accepted);
      beat_t nb;
      in_valid  = iv;
      x         = xi;
      y         = yi;
      z         = zi;
      in_flip   = fl;
      out_ready = ordy;
      #1;
      check("in_ready_a", ir_a, !(m_s2.v && !ordy));
      check("in_ready_b", ir_b, !(m_s2.v && !ordy));
      accepted = iv && !(m_s2.v && !ordy);
      nb = '{v: iv, x: xi, y: yi, z: zi, f: fl};
      @(posedge clk);
      model_edge(nb, ordy);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, {ov_a, ov_b}, 2'b00);
      check({tag, "_in_ready"}, {ir_a, ir_b}, 2'b11);
      check({tag, "_data_a"}, {xo_a, yo_a}, 64'd0);
      check({tag, "_data_b"}, {xo_b, yo_b}, 64'd0);
      check({tag, "_z"}, {zo_a, zo_b}, 64'd0);
      check({tag, "_flags"}, {sf_a, sf_b, sc_a, sc_b}, 34'd0);
   endtask

   initial begin
      logic        acc;
      int          sent;
      int          budget;
      logic [31:0] base;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      x         = '0;
      y         = '0;
      z         = '0;
      in_flip   = 1'b0;
      out_ready = 1'b1;
      model_reset();
      #2;
      check_reset_state("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed beats: unity, rounding, -1.0, flip, saturation, most-negative with flip.
      cycle(1'b1, 32'h0001_0000, 32'h0000_0000, 32'h0000_1234, 1'b0, 1'b1, acc);
      cycle(1'b1, 32'h0000_0003, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 1'b1, acc);
      cycle(1'b1, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0002, 1'b0, 1'b1, acc);
      cycle(1'b1, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0003, 1'b1, 1'b1, acc);
      cycle(1'b1, 32'h4000_0000, 32'hBFFF_FFFF, 32'h0000_0004, 1'b0, 1'b1, acc);
      cycle(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0005, 1'b1, 1'b1, acc);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

      // Backpressure: 8 incrementing-x beats under random out_ready.
      base   = $urandom;
      sent   = 0;
      budget = 0;
      while (sent < 8 && budget < 200) begin
         cycle(1'b1, base + sent, $urandom, 32'(sent), 1'($urandom), 1'($urandom), acc);
         if (acc) sent++;
         budget++;
      end
      check("stream_budget", sent, 8);
      budget = 0;
      while ((m_s1.v || m_s2.v) && budget < 50) begin
         cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'($urandom), acc);
         budget++;
      end
      check("drain_budget", {m_s1.v, m_s2.v}, 2'b00);

      // Random traffic with bubbles and stalls.
      for (int i = 0; i < 60; i++) begin
         cycle(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
               ($urandom_range(0, 3) != 0), acc);
      end

      // Two beats in flight, then asynchronous reset between edges.
      cycle(1'b1, 32'h0002_0000, 32'h1234_5678, 32'hAAAA_0001, 1'b0, 1'b1, acc);
      cycle(1'b1, 32'h7000_0000, 32'h9000_0000, 32'hAAAA_0002, 1'b0, 1'b1, acc);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_state("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
      cycle(1'b1, 32'h0001_0000, 32'h0000_0003, 32'h0000_BEEF, 1'b0, 1'b1, acc);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
